// File: rtl/hex_display_pkg.sv
// Shared types and the hex-to-7-segment table for the HEX display bank.
// Patterns are active-low {g,f,e,d,c,b,a}; polarity is applied by the top level.
package hex_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_DASH  = 7'b0111111;

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        seg7_t pat;
        case (nibble)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational single-digit hex decoder producing the active-low segment pattern.
module seg7_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = hex_to_seg7(nibble_i);

endmodule

// File: rtl/hex_display_ctrl.sv
// Registered multi-digit hex display controller: value capture, leading-zero
// blanking, dash override, free-running blink and selectable segment polarity.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic                    show_dash,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    blink_phase
);

    localparam int          CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam seg7_t       OFF_PAT = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

    seg7_t                   dec_pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    dark;

    assign value_d = load ? value : value_q;
    assign dark    = blink_en && phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A digit is a leading zero while every nibble at or above it is zero; digit 0 always shows.
    always_comb begin
        logic seen_nz;
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (value_q[4*i +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            lz_blank[i] = blank_lz && !seen_nz;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_t pat;

        seg7_decoder u_dec (
            .nibble_i (value_q[4*g +: 4]),
            .seg_o    (dec_pat[g])
        );

        assign pat = dark        ? SEG_BLANK :
                     show_dash   ? SEG_DASH  :
                     lz_blank[g] ? SEG_BLANK :
                                   dec_pat[g];

        assign seg_d[7*g +: 7] = ACTIVE_LOW ? pat : ~pat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= {NUM_DIGITS{OFF_PAT}};
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed literal checks plus randomized
// stimulus compared every cycle against a digit-level behavioural model.
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int BD = 4;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [23:0]   value;
    logic          blank_lz;
    logic          show_dash;
    logic          blink_en;
    logic [41:0]   seg;
    logic          blink_phase;

    logic          load2;
    logic [15:0]   value2;
    logic          zero2;
    logic [27:0]   seg2;
    logic          phase2;

    int testsRun  = 0;
    int testsFail = 0;

    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    logic [6:0] segTable [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [23:0] mValue;
    int          mCnt;
    logic        mPhase;
    logic [41:0] expSeg;

    hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .blank_lz    (blank_lz),
        .show_dash   (show_dash),
        .blink_en    (blink_en),
        .seg         (seg),
        .blink_phase (blink_phase)
    );

    hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(BD), .ACTIVE_LOW(1'b0)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load2),
        .value       (value2),
        .blank_lz    (zero2),
        .show_dash   (zero2),
        .blink_en    (zero2),
        .seg         (seg2),
        .blink_phase (phase2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Display content from first principles: find the most significant non-zero digit, then pick each pattern by priority.
    function automatic logic [41:0] modelSeg(input logic [23:0] v, input logic blz, input logic dash,
                                             input logic dark);
        logic [41:0] r;
        int lead;
        lead = 0;
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) lead = i;
        for (int i = 0; i < ND; i++) begin
            if (dark)                  r[7*i +: 7] = BLK;
            else if (dash)             r[7*i +: 7] = DASH;
            else if (blz && i > lead)  r[7*i +: 7] = BLK;
            else                       r[7*i +: 7] = segTable[v[4*i +: 4]];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValue = '0;
            mCnt   = 0;
            mPhase = 1'b0;
            expSeg = {42{1'b1}};
        end else begin
            expSeg = modelSeg(mValue, blank_lz, show_dash, blink_en && mPhase);
            if (load) mValue = value;
            if (!blink_en) begin
                mCnt   = 0;
                mPhase = 1'b0;
            end else if (mCnt == BD - 1) begin
                mCnt   = 0;
                mPhase = ~mPhase;
            end else begin
                mCnt = mCnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_seg", {22'h0, seg}, {22'h0, expSeg});
            checkOutput("model_phase", {63'h0, blink_phase}, {63'h0, mPhase});
        end
    end

    task automatic applyStimulus(input logic ld, input logic [23:0] val, input logic blz,
                                 input logic dash, input logic ben);
        load      = ld;
        value     = val;
        blank_lz  = blz;
        show_dash = dash;
        blink_en  = ben;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [23:0] randValue();
        logic [23:0] v;
        for (int i = 0; i < ND; i++)
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        load = 1'b0; value = '0; blank_lz = 1'b0; show_dash = 1'b0; blink_en = 1'b0;
        load2 = 1'b0; value2 = '0; zero2 = 1'b0;

        #12;
        checkOutput("reset_seg", {22'h0, seg}, {22'h0, {42{1'b1}}});
        checkOutput("reset_phase", {63'h0, blink_phase}, 64'h0);
        checkOutput("reset_seg_ah", {36'h0, seg2}, 64'h0);

        @(posedge clk); #2;
        rst_n  = 1'b1;
        value2 = 16'h0008;
        load2  = 1'b1;

        applyStimulus(1'b1, 24'h543210, 1'b0, 1'b0, 1'b0);
        load2 = 1'b0;
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("decode_543210", {22'h0, seg},
            {22'h0, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000});
        checkOutput("polarity_0008", {36'h0, seg2},
            {36'h0, 7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111});

        applyStimulus(1'b1, 24'hFEDCBA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("decode_FEDCBA", {22'h0, seg},
            {22'h0, 7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000});

        applyStimulus(1'b1, 24'h000A00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("lz_000A00", {22'h0, seg},
            {22'h0, BLK, BLK, BLK, 7'b0001000, 7'b1000000, 7'b1000000});

        applyStimulus(1'b1, 24'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("lz_zero", {22'h0, seg}, {22'h0, BLK, BLK, BLK, BLK, BLK, 7'b1000000});

        repeat (4) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("blink_phase_4", {63'h0, blink_phase}, 64'h1);
        checkOutput("blink_lit_4", {22'h0, seg}, {22'h0, BLK, BLK, BLK, BLK, BLK, 7'b1000000});
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("blink_dark_5", {22'h0, seg}, {22'h0, {42{1'b1}}});
        repeat (11) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("blink_off_phase", {63'h0, blink_phase}, 64'h0);
        checkOutput("blink_off_lit", {22'h0, seg}, {22'h0, BLK, BLK, BLK, BLK, BLK, 7'b1000000});

        applyStimulus(1'b1, 24'h123456, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("dash_all", {22'h0, seg}, {22'h0, {6{DASH}}});
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("dash_release", {22'h0, seg},
            {22'h0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});
        repeat (5) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("dash_dark", {22'h0, seg}, {22'h0, {42{1'b1}}});
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 3, randValue(), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 15, $urandom_range(0, 9) != 0);
        end

        applyStimulus(1'b1, 24'h9ABCDE, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
        load  = 1'b1;
        value = 24'h111111;
        rst_n = 1'b0;
        #1;
        checkOutput("async_seg", {22'h0, seg}, {22'h0, {42{1'b1}}});
        checkOutput("async_phase", {63'h0, blink_phase}, 64'h0);
        checkOutput("async_seg_ah", {36'h0, seg2}, 64'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_discards_load", {22'h0, seg}, {22'h0, {6{7'b1000000}}});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
